// File: rtl/button_event_decoder.sv
// N-channel pushbutton front end: per channel a 2-FF synchroniser, a debouncer,
// a hold counter and a press classifier that emits one-cycle short / double /
// long / auto-repeat events. Channels are independent instances of one lane.

module button_event_channel #(
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int DOUBLE_MS   = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pressed,
  output logic short_ev,
  output logic double_ev,
  output logic long_ev,
  output logic repeat_ev
);

  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(LONG_MS + REPEAT_MS + 1);
  localparam int GAP_W  = (DOUBLE_MS > 1) ? $clog2(DOUBLE_MS) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_MS);
  localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(LONG_MS + REPEAT_MS);
  // With repeats on, the count folds back so the next repeat is REPEAT_MS away;
  // with repeats off it just parks at LONG_MS.
  localparam logic [HOLD_W-1:0] HOLD_WRAP = (REPEAT_MS > 0) ? HOLD_W'(LONG_MS + 1)
                                                            : HOLD_W'(LONG_MS);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = (DOUBLE_MS > 0) ? GAP_W'(DOUBLE_MS - 1)
                                                            : GAP_W'(0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD1    = 3'd1,
    GAP      = 3'd2,
    HOLD2    = 3'd3,
    LONGHELD = 3'd4
  } state_t;

  logic              sync_a, sync_b;
  logic              deb, deb_d;
  logic [DB_W-1:0]   db_cnt, db_cnt_d;
  logic [HOLD_W-1:0] hold, hold_d;
  logic [GAP_W-1:0]  gap, gap_d;
  state_t            state, state_d;
  logic              short_d, double_d, long_d, repeat_d;

  assign pressed = deb;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= button;
      sync_b <= sync_a;
    end
  end

  // Debounce: count consecutive samples that disagree with the current level;
  // any agreeing sample restarts the count, so short glitches never get through.
  always_comb begin
    deb_d    = deb;
    db_cnt_d = db_cnt;
    if (sync_b == deb) begin
      db_cnt_d = '0;
    end else if (db_cnt == DB_LAST) begin
      deb_d    = sync_b;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt + 1'b1;
    end
  end

  // Hold counter: 1 on the first debounced-high cycle, counts while held,
  // folds back after each repeat point so it never overflows.
  always_comb begin
    hold_d = '0;
    if (deb_d) begin
      if (!deb)                 hold_d = HOLD_W'(1);
      else if (hold == HOLD_TOP) hold_d = HOLD_WRAP;
      else                      hold_d = hold + 1'b1;
    end
  end

  // Debounced level and hold count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb    <= 1'b0;
      db_cnt <= '0;
      hold   <= '0;
    end else begin
      deb    <= deb_d;
      db_cnt <= db_cnt_d;
      hold   <= hold_d;
    end
  end

  // Press classifier: next state, gap timer and event strobes.
  always_comb begin
    state_d  = state;
    gap_d    = gap;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state)
      IDLE: begin
        if (deb) state_d = HOLD1;
      end
      HOLD1: begin
        if (!deb) begin
          if (DOUBLE_MS == 0) begin
            short_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end
        end else if (hold == HOLD_LONG) begin
          long_d  = 1'b1;
          state_d = LONGHELD;
        end
      end
      GAP: begin
        // A new press on the expiry cycle still counts as the second tap.
        if (deb) begin
          state_d = HOLD2;
        end else if (gap == '0) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap - 1'b1;
        end
      end
      HOLD2: begin
        if (!deb) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end else if (hold == HOLD_LONG) begin
          // The first tap is absorbed into the long press.
          long_d  = 1'b1;
          state_d = LONGHELD;
        end
      end
      LONGHELD: begin
        if (!deb) begin
          state_d = IDLE;
        end else if ((REPEAT_MS > 0) && (hold == HOLD_TOP)) begin
          repeat_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Classifier state and registered event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gap       <= '0;
      short_ev  <= 1'b0;
      double_ev <= 1'b0;
      long_ev   <= 1'b0;
      repeat_ev <= 1'b0;
    end else begin
      state     <= state_d;
      gap       <= gap_d;
      short_ev  <= short_d;
      double_ev <= double_d;
      long_ev   <= long_d;
      repeat_ev <= repeat_d;
    end
  end

endmodule

module button_event_decoder #(
  parameter int N_CH        = 2,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int DOUBLE_MS   = 300
) (
  input  logic            clk_1khz_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] pushbutton_i,
  output logic [N_CH-1:0] pressed_o,
  output logic [N_CH-1:0] short_o,
  output logic [N_CH-1:0] double_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] repeat_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_event_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS),
      .DOUBLE_MS   (DOUBLE_MS)
    ) u_ch (
      .clk       (clk_1khz_i),
      .rst       (rst_i),
      .button    (pushbutton_i[g]),
      .pressed   (pressed_o[g]),
      .short_ev  (short_o[g]),
      .double_ev (double_o[g]),
      .long_ev   (long_o[g]),
      .repeat_ev (repeat_o[g])
    );
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: a timestamp-based model of the expected
// outputs is compared every cycle, and directed scenarios pin event counts
// and event times to hand-computed values.

module tb_button_event_decoder;

  localparam int NCH = 2;
  localparam int D   = 10;
  localparam int L   = 1000;
  localparam int R   = 200;
  localparam int DBL = 300;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] btn = '0;
  logic [NCH-1:0] pressed, short_p, dbl_p, long_p, rpt_p;

  always #5 clk = ~clk;

  button_event_decoder #(
    .N_CH(NCH), .DEBOUNCE_MS(D), .LONG_MS(L), .REPEAT_MS(R), .DOUBLE_MS(DBL)
  ) dut (
    .clk_1khz_i   (clk),
    .rst_i        (rst),
    .pushbutton_i (btn),
    .pressed_o    (pressed),
    .short_o      (short_p),
    .double_o     (dbl_p),
    .long_o       (long_p),
    .repeat_o     (rpt_p)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: delayed inputs, last D+1 synchronised samples, press timestamps
  logic           rst_prev = 1'b1;
  logic [NCH-1:0] raw_prev = '0, s1m = '0, deb_p = '0, deb_pp = '0;
  logic [D:0]     win [NCH];
  int             rise_t [NCH];
  int             pend_f [NCH];
  bit             pend   [NCH];
  bit             paired [NCH];

  // observed event statistics per scenario
  int n_short [NCH], n_dbl [NCH], n_long [NCH], n_rep [NCH], n_hi [NCH];
  int t_short [NCH], t_dbl [NCH], t_long [NCH], t_rep0 [NCH], t_repn [NCH];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clr_stats();
    for (int c = 0; c < NCH; c++) begin
      n_short[c] = 0; n_dbl[c] = 0; n_long[c] = 0; n_rep[c] = 0; n_hi[c] = 0;
      t_short[c] = -1; t_dbl[c] = -1; t_long[c] = -1; t_rep0[c] = -1; t_repn[c] = -1;
    end
  endtask

  // One clock cycle: at the falling edge predict and compare this cycle's
  // outputs, then advance past the next rising edge so stimulus can change.
  task automatic tick();
    logic [NCH-1:0] s1_t, s2_t, deb_t, e_sh, e_db, e_lg, e_rp;
    int u, held;
    @(negedge clk);
    s1_t = '0; s2_t = '0; deb_t = '0;
    e_sh = '0; e_db = '0; e_lg = '0; e_rp = '0;
    u = cyc - 1;
    for (int c = 0; c < NCH; c++) begin
      if (rst || rst_prev) begin
        win[c]    = '0;
        pend[c]   = 1'b0;
        paired[c] = 1'b0;
      end else begin
        s1_t[c] = raw_prev[c];
        s2_t[c] = s1m[c];
        // level flips once the last D+1 synchronised samples all disagree with it
        deb_t[c] = (win[c] == {(D+1){~deb_p[c]}}) ? ~deb_p[c] : deb_p[c];
        // press/release timestamps of cycle u decide this cycle's events
        if (deb_p[c] && !deb_pp[c]) begin
          rise_t[c] = u;
          paired[c] = pend[c] && ((u - pend_f[c]) <= DBL);
          pend[c]   = 1'b0;
        end
        if (pend[c] && (u == pend_f[c] + DBL)) begin
          e_sh[c] = 1'b1;
          pend[c] = 1'b0;
        end
        held = u - rise_t[c] + 1;
        if (deb_p[c] && held == L) e_lg[c] = 1'b1;
        if (R > 0 && deb_p[c] && held > L && ((held - L) % R) == 0) e_rp[c] = 1'b1;
        if (!deb_p[c] && deb_pp[c]) begin
          if ((u - rise_t[c]) < L) begin
            if (paired[c])     e_db[c] = 1'b1;
            else if (DBL == 0) e_sh[c] = 1'b1;
            else begin
              pend[c]   = 1'b1;
              pend_f[c] = u;
            end
          end
          paired[c] = 1'b0;
        end
      end
      win[c] = {win[c][D-1:0], s2_t[c]};
    end
    check($sformatf("outputs@cycle%0d", cyc),
          int'({pressed, short_p, dbl_p, long_p, rpt_p}),
          int'({deb_t, e_sh, e_db, e_lg, e_rp}));
    for (int c = 0; c < NCH; c++) begin
      if (pressed[c]) n_hi[c]++;
      if (short_p[c]) begin if (n_short[c] == 0) t_short[c] = cyc; n_short[c]++; end
      if (dbl_p[c])   begin if (n_dbl[c] == 0)   t_dbl[c]   = cyc; n_dbl[c]++;   end
      if (long_p[c])  begin if (n_long[c] == 0)  t_long[c]  = cyc; n_long[c]++;  end
      if (rpt_p[c])   begin if (n_rep[c] == 0)   t_rep0[c]  = cyc; t_repn[c] = cyc; n_rep[c]++; end
    end
    rst_prev = rst;
    raw_prev = btn;
    s1m      = s1_t;
    deb_pp   = deb_p;
    deb_p    = deb_t;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic hold_lvl(input int c, input logic v, input int n);
    btn[c] = v;
    repeat (n) tick();
  endtask

  int p;
  int pat_v [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  int pat_n [8] = '{1, 1, 2, 1, 25, 1, 1, 400};

  initial begin
    for (int c = 0; c < NCH; c++) begin
      win[c] = '0; pend[c] = 1'b0; paired[c] = 1'b0; rise_t[c] = 0; pend_f[c] = 0;
    end
    clr_stats();

    // reset state
    repeat (3) tick();
    check("reset_outputs", int'({pressed, short_p, dbl_p, long_p, rpt_p}), 0);
    rst = 1'b0;
    repeat (20) tick();

    // 1: bounced short press on ch0
    clr_stats();
    p = cyc;
    for (int i = 0; i < 8; i++) hold_lvl(0, pat_v[i][0], pat_n[i]);
    check("t1_short_count", n_short[0], 1);
    check("t1_short_time", t_short[0] - p, 346);
    check("t1_other_events", n_dbl[0] + n_long[0] + n_rep[0] + n_short[1] + n_long[1], 0);
    check("t1_pressed_cycles", n_hi[0], 27);

    // 2: long hold on ch0 with auto-repeat
    clr_stats();
    p = cyc;
    hold_lvl(0, 1'b1, 1590);
    hold_lvl(0, 1'b0, 100);
    check("t2_long_count", n_long[0], 1);
    check("t2_long_time", t_long[0] - p, 1013);
    check("t2_repeat_count", n_rep[0], 2);
    check("t2_repeat_first", t_rep0[0] - p, 1213);
    check("t2_repeat_last", t_repn[0] - p, 1413);
    check("t2_no_short_double", n_short[0] + n_dbl[0], 0);

    // 3: double tap on ch1
    clr_stats();
    p = cyc;
    hold_lvl(1, 1'b1, 50);
    hold_lvl(1, 1'b0, 150);
    hold_lvl(1, 1'b1, 50);
    hold_lvl(1, 1'b0, 400);
    check("t3_double_count", n_dbl[1], 1);
    check("t3_double_time", t_dbl[1] - p, 264);
    check("t3_no_short", n_short[1] + n_long[1] + n_short[0], 0);

    // 4: simultaneous short on ch0 and long hold on ch1
    clr_stats();
    p = cyc;
    btn = 2'b11;
    repeat (25) tick();
    btn[0] = 1'b0;
    repeat (1565) tick();
    btn[1] = 1'b0;
    repeat (400) tick();
    check("t4_short0_time", t_short[0] - p, 339);
    check("t4_long1_time", t_long[1] - p, 1013);
    check("t4_repeat1_count", n_rep[1], 2);
    check("t4_counts", n_short[0] * 1000 + n_long[1] * 100 + n_long[0] * 10 + n_short[1], 1100);
    check("t4_no_double", n_dbl[0] + n_dbl[1] + n_rep[0], 0);

    // 5: reset in the middle of a ch0 hold
    clr_stats();
    p = cyc;
    hold_lvl(0, 1'b1, 500);
    rst = 1'b1;
    tick();
    check("t5_outputs_in_reset", int'({pressed, short_p, dbl_p, long_p, rpt_p}), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (1097) tick();
    hold_lvl(0, 1'b0, 100);
    check("t5_long_count", n_long[0], 1);
    check("t5_long_time", t_long[0] - p, 1516);
    check("t5_no_other", n_short[0] + n_dbl[0] + n_rep[0], 0);

    // 6: short raw pulses on ch1 never debounce
    clr_stats();
    repeat (10) begin
      hold_lvl(1, 1'b1, 5);
      hold_lvl(1, 1'b0, 15);
    end
    repeat (100) tick();
    check("t6_pressed_cycles", n_hi[1], 0);
    check("t6_no_events", n_short[1] + n_dbl[1] + n_long[1] + n_rep[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
